// File: rtl/proc_8085_pipeline.sv
// proc_8085_pipeline: 3-stage IF/ID/EX 8-bit accumulator core with internal IM, register file and DM.
// Define CMP_INSN_EN to add CMP r (13) and CPI imm (14); otherwise both decode as NOP.

module proc_8085_im #(
    parameter int DEPTH = 256
) (
    input  logic [7:0]  addr,
    output logic [15:0] rdata
);
    logic [15:0] IM [0:DEPTH-1];

    assign rdata = IM[addr];
endmodule

module proc_8085_rf (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [2:0] waddr,
    input  logic [7:0] wdata,
    input  logic [2:0] raddr,
    output logic [7:0] rdata
);
    logic [7:0] regfile_8085 [0:6];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 7; i++) regfile_8085[i] <= 8'h00;
        end else if (we) begin
            regfile_8085[waddr] <= wdata;
        end
    end

    assign rdata = (raddr < 3'd7) ? regfile_8085[raddr] : 8'h00;
endmodule

module proc_8085_dm #(
    parameter int DEPTH = 256
) (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);
    logic [7:0] DM [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) DM[addr] <= wdata;
    end

    assign rdata = DM[addr];
endmodule

module proc_8085_pipeline #(
    parameter int    IM_DEPTH = 256,
    parameter int    DM_DEPTH = 256,
    parameter string IM_FILE  = ""
) (
    input  logic clk,
    input  logic rst,
    output logic cy,
    output logic z
);
    typedef enum logic [4:0] {
        OP_NOP = 5'h00, OP_MVI = 5'h01, OP_MOV_AR = 5'h02, OP_MOV_RA = 5'h03,
        OP_ADD = 5'h04, OP_SUB = 5'h05, OP_ANA = 5'h06, OP_ORA = 5'h07,
        OP_XRA = 5'h08, OP_ADI = 5'h09, OP_INR = 5'h0A, OP_DCR = 5'h0B,
        OP_LDA = 5'h0C, OP_STA = 5'h0D, OP_JMP = 5'h0E, OP_JZ = 5'h0F,
        OP_JNZ = 5'h10, OP_JC = 5'h11, OP_JNC = 5'h12, OP_CMP = 5'h13,
        OP_CPI = 5'h14, OP_HLT = 5'h1F
    } op_e;

    logic [7:0]  pc, pc_d;
    logic [7:0]  Accout, acc_d;
    logic        cy_q, cy_d, z_q, z_d, halt_q, halt_d;
    logic [15:0] if_id_q, if_id_d;
    op_e         ex_op_q, ex_op_d, dec_op;
    logic [2:0]  ex_r_q, ex_r_d;
    logic [7:0]  ex_imm_q, ex_imm_d;
    logic [15:0] im_rdata;
    logic [7:0]  rf_rdata, dm_rdata, operand, alu_b, wr_val;
    logic [8:0]  sum9;
    logic        rf_we, dm_we, wr_en, branch_taken, halt_ex;

    proc_8085_im #(.DEPTH(IM_DEPTH)) IM1 (.addr(pc), .rdata(im_rdata));

    proc_8085_rf RF1 (
        .clk(clk), .rst(rst), .we(rf_we), .waddr(ex_r_q), .wdata(wr_val),
        .raddr(ex_r_q), .rdata(rf_rdata)
    );

    // A store in EX on a reset edge must not land in memory.
    proc_8085_dm #(.DEPTH(DM_DEPTH)) DM1 (
        .clk(clk), .we(dm_we & ~rst), .addr(ex_imm_q), .wdata(Accout), .rdata(dm_rdata)
    );

    always_comb begin
        dec_op = OP_NOP;
        case (if_id_q[15:11])
            5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09,
            5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h0F, 5'h10, 5'h11, 5'h12,
            5'h1F: dec_op = op_e'(if_id_q[15:11]);
`ifdef CMP_INSN_EN
            5'h13, 5'h14: dec_op = op_e'(if_id_q[15:11]);
`endif
            default: dec_op = OP_NOP;
        endcase
    end

    always_comb begin
        operand      = (ex_r_q == 3'd7) ? Accout : rf_rdata;
        alu_b        = (ex_op_q == OP_ADI || ex_op_q == OP_CPI) ? ex_imm_q : operand;
        sum9         = {1'b0, Accout} + {1'b0, alu_b};
        acc_d        = Accout;
        cy_d         = cy_q;
        z_d          = z_q;
        wr_en        = 1'b0;
        wr_val       = 8'h00;
        dm_we        = 1'b0;
        branch_taken = 1'b0;
        halt_ex      = 1'b0;
        case (ex_op_q)
            OP_MVI:    begin wr_en = 1'b1; wr_val = ex_imm_q; end
            OP_MOV_AR: acc_d = operand;
            OP_MOV_RA: begin wr_en = 1'b1; wr_val = Accout; end
            OP_ADD, OP_ADI: begin acc_d = sum9[7:0]; cy_d = sum9[8]; z_d = ~|sum9[7:0]; end
            OP_SUB:    begin acc_d = Accout - alu_b; cy_d = Accout < alu_b; z_d = Accout == alu_b; end
            OP_CMP, OP_CPI: begin cy_d = Accout < alu_b; z_d = Accout == alu_b; end
            OP_ANA:    begin acc_d = Accout & operand; cy_d = 1'b0; z_d = ~|acc_d; end
            OP_ORA:    begin acc_d = Accout | operand; cy_d = 1'b0; z_d = ~|acc_d; end
            OP_XRA:    begin acc_d = Accout ^ operand; cy_d = 1'b0; z_d = ~|acc_d; end
            OP_INR:    begin wr_en = 1'b1; wr_val = operand + 8'd1; z_d = ~|wr_val; end
            OP_DCR:    begin wr_en = 1'b1; wr_val = operand - 8'd1; z_d = ~|wr_val; end
            OP_LDA:    acc_d = dm_rdata;
            OP_STA:    dm_we = 1'b1;
            OP_JMP:    branch_taken = 1'b1;
            OP_JZ:     branch_taken = z_q;
            OP_JNZ:    branch_taken = ~z_q;
            OP_JC:     branch_taken = cy_q;
            OP_JNC:    branch_taken = ~cy_q;
            OP_HLT:    halt_ex = 1'b1;
            default:   ;
        endcase
        if (wr_en && ex_r_q == 3'd7) acc_d = wr_val;
        rf_we = wr_en && (ex_r_q != 3'd7);
    end

    // Taken branches and halt both squash the two younger slots.
    always_comb begin
        pc_d     = pc + 8'd1;
        if_id_d  = im_rdata;
        ex_op_d  = dec_op;
        ex_r_d   = if_id_q[10:8];
        ex_imm_d = if_id_q[7:0];
        halt_d   = halt_q;
        if (halt_q || halt_ex) begin
            halt_d   = 1'b1;
            pc_d     = pc;
            if_id_d  = 16'h0000;
            ex_op_d  = OP_NOP;
            ex_r_d   = 3'd0;
            ex_imm_d = 8'h00;
        end else if (branch_taken) begin
            pc_d     = ex_imm_q;
            if_id_d  = 16'h0000;
            ex_op_d  = OP_NOP;
            ex_r_d   = 3'd0;
            ex_imm_d = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= 8'h00;
            Accout   <= 8'h00;
            cy_q     <= 1'b0;
            z_q      <= 1'b0;
            halt_q   <= 1'b0;
            if_id_q  <= 16'h0000;
            ex_op_q  <= OP_NOP;
            ex_r_q   <= 3'd0;
            ex_imm_q <= 8'h00;
        end else begin
            pc       <= pc_d;
            Accout   <= acc_d;
            cy_q     <= cy_d;
            z_q      <= z_d;
            halt_q   <= halt_d;
            if_id_q  <= if_id_d;
            ex_op_q  <= ex_op_d;
            ex_r_q   <= ex_r_d;
            ex_imm_q <= ex_imm_d;
        end
    end

    assign cy = cy_q;
    assign z  = z_q;
endmodule

// File: tb/tb_proc_8085_pipeline.sv
// Bench for proc_8085_pipeline: ISA-level reference model with a 2-slot in-flight queue, checked every cycle.
// Directed programs pin the model; random forward-branching programs exercise the rest.

module tb_proc_8085_pipeline;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cy, z;

    proc_8085_pipeline dut (.clk(clk), .rst(rst), .cy(cy), .z(z));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic [15:0] im_img [0:255];
    logic [7:0]  m_pc, m_acc;
    logic        m_cy, m_z, m_halt;
    logic [7:0]  m_rf [0:6];
    logic [7:0]  m_dm [0:255];
    bit          m_dm_known [0:255];
    logic [15:0] m_pipe [$];
    bit          started = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] r, input logic [7:0] k);
        return {op, r, k};
    endfunction

    function automatic logic [7:0] m_get(input logic [2:0] r);
        return (r == 3'd7) ? m_acc : m_rf[r];
    endfunction

    task automatic m_set(input logic [2:0] r, input logic [7:0] v);
        if (r == 3'd7) m_acc = v;
        else m_rf[r] = v;
    endtask

    task automatic m_reset();
        m_pc = 8'h00; m_acc = 8'h00; m_cy = 1'b0; m_z = 1'b0; m_halt = 1'b0;
        for (int i = 0; i < 7; i++) m_rf[i] = 8'h00;
        m_pipe.delete();
        m_pipe.push_back(16'h0000);
        m_pipe.push_back(16'h0000);
        started = 1'b1;
    endtask

    // One clock of the machine: the oldest in-flight word executes, then a new word is fetched.
    task automatic m_step();
        logic [15:0] w;
        logic [4:0]  op;
        logic [2:0]  r;
        logic [7:0]  k, v;
        int a, b, s;
        bit taken, hlt;
        if (m_halt) return;
        w = m_pipe.pop_front();
        op = w[15:11]; r = w[10:8]; k = w[7:0];
        a = int'(m_acc); taken = 1'b0; hlt = 1'b0;
        case (op)
            5'h01: m_set(r, k);
            5'h02: m_acc = m_get(r);
            5'h03: m_set(r, m_acc);
            5'h04, 5'h09: begin
                b = (op == 5'h09) ? int'(k) : int'(m_get(r));
                s = a + b;
                m_cy = (s > 255); m_acc = 8'(s); m_z = (m_acc == 8'h00);
            end
            5'h05: begin
                b = int'(m_get(r));
                m_cy = (a < b); m_acc = 8'(a - b); m_z = (m_acc == 8'h00);
            end
            5'h06: begin m_acc = m_acc & m_get(r); m_cy = 1'b0; m_z = (m_acc == 8'h00); end
            5'h07: begin m_acc = m_acc | m_get(r); m_cy = 1'b0; m_z = (m_acc == 8'h00); end
            5'h08: begin m_acc = m_acc ^ m_get(r); m_cy = 1'b0; m_z = (m_acc == 8'h00); end
            5'h0A: begin v = 8'(int'(m_get(r)) + 1); m_set(r, v); m_z = (v == 8'h00); end
            5'h0B: begin v = 8'(int'(m_get(r)) - 1); m_set(r, v); m_z = (v == 8'h00); end
            5'h0C: m_acc = m_dm[k];
            5'h0D: begin m_dm[k] = m_acc; m_dm_known[k] = 1'b1; end
            5'h0E: taken = 1'b1;
            5'h0F: taken = m_z;
            5'h10: taken = !m_z;
            5'h11: taken = m_cy;
            5'h12: taken = !m_cy;
            5'h13, 5'h14: begin
`ifdef CMP_INSN_EN
                b = (op == 5'h14) ? int'(k) : int'(m_get(r));
                m_cy = (a < b); m_z = (a == b);
`endif
            end
            5'h1F: hlt = 1'b1;
            default: ;
        endcase
        if (hlt) begin
            m_halt = 1'b1;
        end else if (taken) begin
            m_pipe.delete();
            m_pipe.push_back(16'h0000);
            m_pipe.push_back(16'h0000);
            m_pc = k;
        end else begin
            m_pipe.push_back(im_img[m_pc]);
            m_pc = m_pc + 8'd1;
        end
    endtask

    always @(posedge clk) begin
        if (rst) m_reset();
        else if (started) m_step();
    end

    always @(negedge clk) begin
        if (started) begin
            check("pc", dut.pc, m_pc);
            check("acc", dut.Accout, m_acc);
            check("cy", {7'b0, cy}, {7'b0, m_cy});
            check("z", {7'b0, z}, {7'b0, m_z});
            for (int i = 0; i < 7; i++) check($sformatf("rf[%0d]", i), dut.RF1.regfile_8085[i], m_rf[i]);
            for (int i = 0; i < 256; i++)
                if (m_dm_known[i]) check($sformatf("dm[%0d]", i), dut.DM1.DM[i], m_dm[i]);
        end
    end

    task automatic load_word(input int a, input logic [15:0] w);
        im_img[a] = w;
        dut.IM1.IM[a] = w;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) load_word(i, enc(5'h1F, 3'd0, 8'h00));
    endtask

    task automatic hold_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        check("rst_pc", dut.pc, 8'h00);
        check("rst_acc", dut.Accout, 8'h00);
        check("rst_cy", {7'b0, cy}, 8'h00);
        check("rst_z", {7'b0, z}, 8'h00);
        for (int i = 0; i < 7; i++) check($sformatf("rst_rf[%0d]", i), dut.RF1.regfile_8085[i], 8'h00);
        rst = 1'b0;
    endtask

    task automatic run_until_halt(input int bound);
        for (int c = 0; c < bound && !m_halt; c++) @(negedge clk);
        if (!m_halt) begin
            n_cmp++; n_fail++;
            $display("FAIL halt_timeout: got running expected halted within %0d cycles", bound);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic gen_random_prog();
        int sel, t;
        logic [4:0] op;
        logic [2:0] r;
        logic [7:0] k;
        clear_prog();
        for (int i = 0; i < 8; i++) begin
            load_word(2 * i, enc(5'h01, 3'd7, 8'($urandom_range(0, 255))));
            load_word(2 * i + 1, enc(5'h0D, 3'd0, 8'(8'h40 + i)));
        end
        for (int a = 16; a < 64; a++) begin
            sel = $urandom_range(0, 21);
            op = (sel <= 20) ? 5'(sel) : 5'($urandom_range(21, 30));
            r = 3'($urandom_range(0, 7));
            k = 8'($urandom_range(0, 255));
            if (op == 5'h0C || op == 5'h0D) k = 8'(8'h40 + $urandom_range(0, 7));
            if (op >= 5'h0E && op <= 5'h12) begin
                t = a + $urandom_range(1, 6);
                if (t > 64) t = 64;
                k = 8'(t);
            end
            load_word(a, enc(op, r, k));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) m_dm_known[i] = 1'b0;

        // Add with carry out, then a clean add.
        hold_reset();
        clear_prog();
        load_word(0, enc(5'h01, 3'd7, 8'hFF));
        load_word(1, enc(5'h09, 3'd0, 8'h01));
        load_word(2, enc(5'h09, 3'd0, 8'h05));
        release_reset();
        repeat (4) @(negedge clk);
        check("p1_acc", dut.Accout, 8'h00);
        check("p1_cy", {7'b0, cy}, 8'h01);
        check("p1_z", {7'b0, z}, 8'h01);
        check("p1_model_acc", m_acc, 8'h00);
        check("p1_model_cy", {7'b0, m_cy}, 8'h01);
        @(negedge clk);
        check("p1b_acc", dut.Accout, 8'h05);
        check("p1b_cy", {7'b0, cy}, 8'h00);
        check("p1b_z", {7'b0, z}, 8'h00);
        run_until_halt(50);

        // Store, clobber, load back, store again.
        hold_reset();
        clear_prog();
        load_word(0, enc(5'h01, 3'd7, 8'h3C));
        load_word(1, enc(5'h0D, 3'd0, 8'h40));
        load_word(2, enc(5'h01, 3'd7, 8'h00));
        load_word(3, enc(5'h0C, 3'd0, 8'h40));
        load_word(4, enc(5'h0D, 3'd0, 8'h41));
        release_reset();
        run_until_halt(50);
        check("p2_dm64", dut.DM1.DM[64], 8'h3C);
        check("p2_dm65", dut.DM1.DM[65], 8'h3C);
        check("p2_acc", dut.Accout, 8'h3C);

        // Countdown loop; the HLT behind each taken JNZ must be squashed.
        hold_reset();
        clear_prog();
        load_word(0, enc(5'h01, 3'd4, 8'h05));
        load_word(1, enc(5'h0B, 3'd4, 8'h00));
        load_word(2, enc(5'h10, 3'd0, 8'h01));
        load_word(4, enc(5'h0A, 3'd1, 8'h00));
        release_reset();
        run_until_halt(100);
        check("p3_h", dut.RF1.regfile_8085[4], 8'h00);
        check("p3_c", dut.RF1.regfile_8085[1], 8'h00);
        check("p3_z", {7'b0, z}, 8'h01);
        check("p3_pc", dut.pc, 8'h05);
        repeat (5) @(negedge clk);
        check("p3_pc_frozen", dut.pc, 8'h05);

        // Not-taken JZ costs no bubble.
        hold_reset();
        clear_prog();
        load_word(0, enc(5'h0F, 3'd0, 8'h10));
        load_word(1, enc(5'h01, 3'd0, 8'hAA));
        release_reset();
        repeat (4) @(negedge clk);
        check("p4_b", dut.RF1.regfile_8085[0], 8'hAA);
        check("p4_pc", dut.pc, 8'h04);
        run_until_halt(50);

        // Compare immediate; flags start at cy=1 z=1 so a NOP decode is visible.
        hold_reset();
        clear_prog();
        load_word(0, enc(5'h01, 3'd7, 8'hFF));
        load_word(1, enc(5'h09, 3'd0, 8'h01));
        load_word(2, enc(5'h01, 3'd7, 8'h10));
        load_word(3, enc(5'h14, 3'd0, 8'h20));
        load_word(4, enc(5'h14, 3'd0, 8'h10));
        release_reset();
        repeat (6) @(negedge clk);
        check("p5_acc", dut.Accout, 8'h10);
`ifdef CMP_INSN_EN
        check("p5_cy", {7'b0, cy}, 8'h01);
        check("p5_z", {7'b0, z}, 8'h00);
        @(negedge clk);
        check("p5b_cy", {7'b0, cy}, 8'h00);
        check("p5b_z", {7'b0, z}, 8'h01);
`else
        check("p5_cy", {7'b0, cy}, 8'h01);
        check("p5_z", {7'b0, z}, 8'h01);
        @(negedge clk);
        check("p5b_cy", {7'b0, cy}, 8'h01);
        check("p5b_z", {7'b0, z}, 8'h01);
`endif
        check("p5b_acc", dut.Accout, 8'h10);
        run_until_halt(50);

        // Random programs, one of them interrupted by a mid-stream reset.
        for (int t = 0; t < 5; t++) begin
            hold_reset();
            gen_random_prog();
            release_reset();
            if (t == 2) begin
                repeat ($urandom_range(20, 60)) @(negedge clk);
                rst = 1'b1;
                release_reset();
            end
            run_until_halt(400);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
